// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for register_file_v2
package regfile_pkg;

  // Bit positions inside reg_file_error_vector
  localparam int ERR_ZERO_WR   = 0;
  localparam int ERR_WW_COLL   = 1;
  localparam int ERR_LINK_COLL = 2;
  localparam int ERR_RANGE     = 3;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [3:0] regfile_err_t;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - resolves port and link writes into per-register updates
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int NREGS       = NREGS_DEFAULT,
  parameter int NWR         = 2,
  parameter int AW          = 5,
  parameter int LINK_REG    = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  link_en,
  input  logic [XLEN-1:0]       link_data,
  output logic [NREGS-1:0]      reg_we,
  output logic [NREGS*XLEN-1:0] reg_wd,
  output logic                  err_zero_wr,
  output logic                  err_ww_coll,
  output logic                  err_link_coll,
  output logic                  err_wr_range
);

  // Per-register winner: link first, then ports in ascending order so the
  // highest-numbered port overwrites everything below it.
  always_comb begin
    reg_we = '0;
    reg_wd = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (!(ZERO_REG_EN != 0 && i == 0)) begin
        if (link_en && LINK_REG == i) begin
          reg_we[i]                = 1'b1;
          reg_wd[i*XLEN +: XLEN]   = link_data;
        end
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(i)) begin
            reg_we[i]              = 1'b1;
            reg_wd[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Write-side error detection; out-of-range addresses simply never match above.
  always_comb begin
    err_zero_wr   = 1'b0;
    err_ww_coll   = 1'b0;
    err_link_coll = 1'b0;
    err_wr_range  = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) begin
        if (ZERO_REG_EN != 0 && wr_addr[p*AW +: AW] == '0) err_zero_wr = 1'b1;
        if (32'(wr_addr[p*AW +: AW]) >= NREGS) err_wr_range = 1'b1;
        if (link_en && 32'(wr_addr[p*AW +: AW]) == LINK_REG) err_link_coll = 1'b1;
        for (int q = 0; q < p; q++) begin
          if (wr_en[q] && wr_addr[q*AW +: AW] == wr_addr[p*AW +: AW]) err_ww_coll = 1'b1;
        end
      end
    end
    if (link_en) begin
      if (ZERO_REG_EN != 0 && LINK_REG == 0) err_zero_wr = 1'b1;
      if (LINK_REG >= NREGS) err_wr_range = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_v2.sv
// rtl/register_file_v2.sv - multi-port register file with write-first bypass and sticky errors
module register_file_v2
  import regfile_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int NREGS       = NREGS_DEFAULT,
  parameter int NRD         = 2,
  parameter int NWR         = 2,
  parameter int LINK_REG    = 1,
  parameter int ZERO_REG_EN = 1,
  localparam int AW         = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                link_en,
  input  logic [XLEN-1:0]     link_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  input  logic                err_clr,
  output logic [3:0]          reg_file_error_vector
);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NRD*XLEN-1:0]   rd_data_q, rd_data_d;
  logic [NRD-1:0]        rd_valid_q, rd_valid_d;
  regfile_err_t          err_q, err_d;

  logic [NREGS-1:0]      reg_we;
  logic [NREGS*XLEN-1:0] reg_wd;
  logic                  err_zero_wr, err_ww_coll, err_link_coll, err_wr_range;

  regfile_wr_arbiter #(
    .XLEN        (XLEN),
    .NREGS       (NREGS),
    .NWR         (NWR),
    .AW          (AW),
    .LINK_REG    (LINK_REG),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_arb (
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .link_en       (link_en),
    .link_data     (link_data),
    .reg_we        (reg_we),
    .reg_wd        (reg_wd),
    .err_zero_wr   (err_zero_wr),
    .err_ww_coll   (err_ww_coll),
    .err_link_coll (err_link_coll),
    .err_wr_range  (err_wr_range)
  );

  // Next register contents from the arbitrated write set
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = reg_we[i] ? reg_wd[i*XLEN +: XLEN] : regs_q[i];
    end
  end

  // Read capture with write-first bypass; register 0 and out-of-range read as 0
  always_comb begin
    logic            rd_range;
    logic [XLEN-1:0] val;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    rd_range   = 1'b0;
    val        = '0;
    for (int r = 0; r < NRD; r++) begin
      val = '0;
      for (int i = 0; i < NREGS; i++) begin
        if (rd_addr[r*AW +: AW] == AW'(i) && !(ZERO_REG_EN != 0 && i == 0)) begin
          val = reg_we[i] ? reg_wd[i*XLEN +: XLEN] : regs_q[i];
        end
      end
      if (rd_en[r]) begin
        rd_data_d[r*XLEN +: XLEN] = val;
        if (32'(rd_addr[r*AW +: AW]) >= NREGS) rd_range = 1'b1;
      end
    end
    err_d                = err_clr ? '0 : err_q;
    err_d[ERR_ZERO_WR]   = err_d[ERR_ZERO_WR]   | err_zero_wr;
    err_d[ERR_WW_COLL]   = err_d[ERR_WW_COLL]   | err_ww_coll;
    err_d[ERR_LINK_COLL] = err_d[ERR_LINK_COLL] | err_link_coll;
    err_d[ERR_RANGE]     = err_d[ERR_RANGE]     | err_wr_range | rd_range;
  end

  // State update; reset discards everything presented in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      err_q      <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data               = rd_data_q;
  assign rd_valid              = rd_valid_q;
  assign reg_file_error_vector = err_q;

endmodule

// File: doc/register_file_v2.md
Name: register_file_v2

Overview:
- Parametrised successor to the v1 two-port register file in the riscv_core datapath.
- Provides NWR write ports and NRD read ports.
- Reads are registered with a 1-cycle latency, and same-cycle writes are bypassed to readers.
- A link-register write path, a hardwired zero register, and sticky error flags with software clear sit between decode and the ALU operand latches.

Parameters:
- XLEN, 32: register width in bits.
- NREGS, 32: number of architectural registers (2..32).
- AW, $clog2(NREGS) (min 1): register address width; derived, not overridden.
- NRD, 2: number of read ports (1..4).
- NWR, 2: number of write ports (1..4).
- LINK_REG, 1: index written by the link path.
- ZERO_REG_EN, 1: 1 means register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses, port p at [p*AW +: AW].
- wr_data  in  NWR*XLEN  packed write data.
- link_en  in  1  link write request.
- link_data  in  XLEN  return address to store in LINK_REG.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  packed read addresses.
- rd_data  out  NRD*XLEN  registered read data.
- rd_valid  out  NRD  asserted 1 cycle after the matching rd_en.
- err_clr  in  1  clears reg_file_error_vector.
- reg_file_error_vector  out  4  sticky error flags.

Behaviour:
- Reset: at a posedge clk with rst==0:
  - all registers, rd_data and rd_valid go to 0;
  - reg_file_error_vector goes to 0;
  - all same-cycle writes and reads are discarded.
- Write commit: at the posedge of the cycle the enables are presented.
  - Priority per address, highest first: port NWR-1, ..., port 0, then link.
  - Port writes override a link write to the same address.
- Zero register (ZERO_REG_EN=1):
  - writes to address 0 are dropped;
  - a read of address 0 returns 0, including via bypass.
- Read: with rd_en[r]=1 in cycle N:
  - rd_data[r] = register contents in cycle N+1, and rd_valid[r]=1 in cycle N+1;
  - write-first bypass: if any enabled write or link targets rd_addr[r] in cycle N, rd_data returns the highest-priority write data.
- rd_en[r]=0: rd_data[r] holds its previous value and rd_valid[r]=0 the next cycle.
- Out-of-range addresses (address >= NREGS, possible only when NREGS is not a power of 2):
  - such writes are dropped;
  - such reads return 0 with rd_valid still asserted.
- reg_file_error_vector bits:
  - [0] a write or link targeted register 0 while ZERO_REG_EN=1;
  - [1] two or more enabled write ports targeted the same address in one cycle;
  - [2] link_en collided with an enabled write port on LINK_REG;
  - [3] an enabled read or write used an out-of-range address.
- Error flag timing:
  - flags set at the posedge after detection and stay set until err_clr or reset;
  - err_clr takes effect at the next posedge;
  - if err_clr and a new error occur in the same cycle, the new error wins (the flag stays 1).
- Each register updates at most once per clock; there is no read-during-reset data.
- Design is fully synchronous with no combinational output path; rd_data depends only on flops.

Decomposition:
- regfile_pkg holds:
  - error-bit index localparams ERR_ZERO_WR=0, ERR_WW_COLL=1, ERR_LINK_COLL=2, ERR_RANGE=3;
  - the typedef regfile_err_t (logic [3:0]);
  - XLEN_DEFAULT and NREGS_DEFAULT.
- One sub-module, regfile_wr_arbiter (combinational): resolves per-register write enable and data from ports and link, and produces collision flags.
- The register array, bypass and read flops stay in the top.

Test Plan:
- Zero register: wr_en=2'b11, both addresses 0, data 5 and 5, then read ports 0 and 1 at address 0 -> rd_data 0/0, error bit[0]=1.
- Dual write: port0 writes x1=15 and port1 writes x2=20, next cycle read x1 and x2 -> rd_data 15/20, rd_valid=2'b11 exactly 1 cycle after rd_en, error vector 0.
- Write-write collision: port0 writes x5=0xAAAA_AAAA and port1 writes x5=0x5555_5555, then read x5 -> 0x5555_5555, bit[1]=1. Then err_clr=1 for one cycle -> vector 0.
- Link and bypass: link_en=1 with link_data=0x0000_1004, read x1 in the same cycle -> rd_data 0x0000_1004 next cycle. Then link_en with port0 writing x1=7 -> x1=7, bit[2]=1.
- Reset mid-operation: write x3=0xDEAD_BEEF, then rst=0 in the same cycle as a write of x4=9 -> after release, reads of x3 and x4 give 0/0, rd_valid 0 during reset, vector 0.
- Parameter sweep (NREGS=24, NRD=3, NWR=1): write x30 -> dropped and bit[3]=1; read x23 after writing 0x17 -> 0x17 on all three ports.
